// File: rtl/parity_enc_arbiter.sv
// parity_enc_arbiter: round-robin arbiter feeding a shared parity encoder into a one-entry valid/ready output register
module parity_enc_arbiter #(
    parameter int NREQ       = 4,
    parameter int ID_W       = 2,
    parameter int DATA_W     = 4,
    parameter int ODD_PARITY = 0,
    parameter int CNT_W      = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*DATA_W-1:0] req_data,
    output logic [NREQ-1:0]        gnt,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_W:0]        out_data,
    output logic [ID_W-1:0]        out_id,
    output logic [CNT_W-1:0]       enc_count
);
    typedef enum logic {EMPTY, FULL} state_t;
    state_t            state_q, state_d;
    logic [ID_W-1:0]   ptr_q, ptr_d, id_q, id_d, sel, hi, lo;
    logic [DATA_W:0]   data_q, data_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] word;
    logic              any_hi, any_lo, take;
    always_comb begin
        hi = '0;
        lo = '0;
        any_hi = 1'b0;
        any_lo = 1'b0;
        word = '0;
        // descending scan: the last hit is the lowest index, at/above ptr_q (hi) or overall (lo, the wrap case)
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                lo = ID_W'(i);
                any_lo = 1'b1;
                if (i >= int'(ptr_q)) begin
                    hi = ID_W'(i);
                    any_hi = 1'b1;
                end
            end
        end
        sel = any_hi ? hi : lo;
        take = rst_n && any_lo && (state_q == EMPTY || out_ready);
        for (int i = 0; i < NREQ; i++) begin
            gnt[i] = take && ID_W'(i) == sel;
            if (ID_W'(i) == sel) word = req_data[i*DATA_W +: DATA_W];
        end
        state_d = take ? FULL : (out_ready ? EMPTY : state_q);
        ptr_d = take ? (int'(sel) == NREQ - 1 ? '0 : sel + ID_W'(1)) : ptr_q;
        data_d = take ? {word, ^word ^ 1'(ODD_PARITY)} : data_q;
        id_d = take ? sel : id_q;
        cnt_d = cnt_q + CNT_W'(take);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            ptr_q <= '0;
            data_q <= '0;
            id_q <= '0;
            cnt_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q <= ptr_d;
            data_q <= data_d;
            id_q <= id_d;
            cnt_q <= cnt_d;
        end
    end
    assign out_valid = state_q == FULL;
    assign out_data = data_q;
    assign out_id = id_q;
    assign enc_count = cnt_q;
endmodule

// File: tb/tb_parity_enc_arbiter.sv
// tb_parity_enc_arbiter: directed vector table plus hand-written backpressure and reset sequences
module tb_parity_enc_arbiter;
    logic        clk, rst_n, out_ready;
    logic [3:0]  req, gnt, gnt2;
    logic [15:0] req_data;
    logic        out_valid, out_valid2;
    logic [4:0]  out_data, out_data2;
    logic [1:0]  out_id, out_id2;
    logic [15:0] enc_count;
    logic [3:0]  enc_count2;
    int passes = 0;
    int total = 0;

    typedef struct {
        logic [3:0]  req;
        logic [15:0] data;
        logic [3:0]  gnt;
        logic [4:0]  cw;
        logic [1:0]  id;
    } vec_t;
    vec_t tv [28];
    logic [4:0] rr_cw [4];

    parity_enc_arbiter dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .gnt(gnt),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_id(out_id), .enc_count(enc_count)
    );
    // odd parity, 4-bit counter copy sharing the same inputs
    parity_enc_arbiter #(.ODD_PARITY(1), .CNT_W(4)) dut2 (
        .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .gnt(gnt2),
        .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2),
        .out_id(out_id2), .enc_count(enc_count2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        else passes++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] nib;
        rr_cw = '{5'h03, 5'h05, 5'h09, 5'h11};
        tv[0] = '{4'b0001, 16'h000B, 4'b0001, 5'b10111, 2'd0};
        for (int v = 0; v < 16; v++) begin
            nib = v[3:0];
            tv[1+v] = '{4'b0100, {4'h0, nib, 8'h00}, 4'b0100, {nib, 1'($countones(nib) % 2)}, 2'd2};
        end
        tv[17] = '{4'b1001, 16'h8421, 4'b1000, 5'h11, 2'd3};
        tv[18] = '{4'b0100, 16'h8421, 4'b0100, 5'h09, 2'd2};
        tv[19] = '{4'b1000, 16'h8421, 4'b1000, 5'h11, 2'd3};
        for (int k = 0; k < 8; k++)
            tv[20+k] = '{4'b1111, 16'h8421, 4'b0001 << (k % 4), rr_cw[k%4], 2'(k % 4)};

        rst_n = 1'b0;
        req = 4'b1111;
        req_data = '0;
        out_ready = 1'b0;
        #2;
        chk("rst_gnt", gnt, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_id", out_id, 0);
        chk("rst_cnt", enc_count, 0);
        chk("rst_cnt4", enc_count2, 0);
        step();
        req = '0;
        out_ready = 1'b1;
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 28; i++) begin
            req = tv[i].req;
            req_data = tv[i].data;
            #1;
            chk($sformatf("gnt[%0d]", i), gnt, tv[i].gnt);
            step();
            chk($sformatf("valid[%0d]", i), out_valid, 1);
            chk($sformatf("data[%0d]", i), out_data, tv[i].cw);
            chk($sformatf("id[%0d]", i), out_id, tv[i].id);
            chk($sformatf("cnt[%0d]", i), enc_count, i + 1);
            chk($sformatf("odd_data[%0d]", i), out_data2, tv[i].cw ^ 5'd1);
            chk($sformatf("cnt4[%0d]", i), enc_count2, (i + 1) % 16);
        end

        out_ready = 1'b0;
        req = 4'b0110;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("bp_gnt", gnt, 0);
            step();
            chk("bp_valid", out_valid, 1);
            chk("bp_data", out_data, 5'h11);
            chk("bp_id", out_id, 3);
        end
        out_ready = 1'b1;
        #1;
        chk("pop_gnt", gnt, 4'b0010);
        step();
        chk("pop_valid", out_valid, 1);
        chk("pop_id", out_id, 1);
        chk("pop_data", out_data, 5'h05);
        chk("pop_cnt", enc_count, 29);
        req = '0;
        #1;
        chk("idle_gnt", gnt, 0);
        step();
        chk("drain_valid", out_valid, 0);
        chk("drain_cnt", enc_count, 29);

        req = 4'b1111;
        out_ready = 1'b0;
        #1;
        chk("mid_gnt", gnt, 4'b0100);
        step();
        chk("mid_valid", out_valid, 1);
        chk("mid_id", out_id, 2);
        chk("mid_cnt", enc_count, 30);
        rst_n = 1'b0;
        #1;
        chk("async_valid", out_valid, 0);
        chk("async_cnt", enc_count, 0);
        chk("async_cnt4", enc_count2, 0);
        chk("async_gnt", gnt, 0);
        step();
        rst_n = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("restart_gnt", gnt, 4'b0001);
        step();
        chk("restart_id", out_id, 0);
        chk("restart_data", out_data, 5'h03);
        chk("restart_cnt", enc_count, 1);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
